// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: constants, state encoding and saturation limits shared by
// the partial-sum drain block and its saturating adder.
// Build option: PSUM_DRAIN_DOUBLE_BUF_EN selects two tile banks (default one).
package psum_drain_pkg;

  localparam int ROWS        = 16;
  localparam int LANES       = 16;
  localparam int PSUM_W      = 24;
  localparam int ROW_W       = $clog2(ROWS);
  localparam int DRAIN_BEATS = 17;
  localparam int CNT_W       = $clog2(DRAIN_BEATS + 1);

  localparam logic [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

`ifdef PSUM_DRAIN_DOUBLE_BUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/psum_sat_add.sv
// psum_sat_add: LANES-wide combinational overwrite / saturating add of one
// tile row.
//   row_in  - current row contents
//   add_in  - incoming lane values
//   first   - 1: sum_out = add_in (no saturation possible)
//   sum_out - new row contents
//   sat     - per-lane clamp indicator
module psum_sat_add
  import psum_drain_pkg::*;
(
  input  logic [LANES*PSUM_W-1:0] row_in,
  input  logic [LANES*PSUM_W-1:0] add_in,
  input  logic                    first,
  output logic [LANES*PSUM_W-1:0] sum_out,
  output logic [LANES-1:0]        sat
);

  logic [PSUM_W-1:0] a;
  logic [PSUM_W-1:0] b;
  logic [PSUM_W:0]   wide;

  always_comb begin
    sum_out = '0;
    sat     = '0;
    a       = '0;
    b       = '0;
    wide    = '0;
    for (int j = 0; j < LANES; j++) begin
      a    = row_in[j*PSUM_W +: PSUM_W];
      b    = add_in[j*PSUM_W +: PSUM_W];
      wide = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
      if (first) begin
        sum_out[j*PSUM_W +: PSUM_W] = b;
      end else if (wide[PSUM_W] != wide[PSUM_W-1]) begin
        // Overflow: the extra sign bit tells which rail was crossed.
        sum_out[j*PSUM_W +: PSUM_W] = wide[PSUM_W] ? SAT_MIN : SAT_MAX;
        sat[j] = 1'b1;
      end else begin
        sum_out[j*PSUM_W +: PSUM_W] = wide[PSUM_W-1:0];
      end
    end
  end

endmodule

// File: rtl/psum_drain.sv
// psum_drain: PPU partial-sum transmit side. Accumulates a ROWS x LANES tile
// of signed partial sums over K steps, then streams it to the PPU as a
// DRAIN_BEATS burst (preamble beat = row 0, then rows 0..ROWS-1) with scale
// and bias held, and waits for ppu_done before releasing the tile buffer.
// Build option: PSUM_DRAIN_DOUBLE_BUF_EN adds a second bank so accumulation
// continues while the other bank drains.
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   acc_valid/acc_ready            - accumulation beat handshake
//   acc_row/acc_first/acc_last     - row address, overwrite, final K step
//   acc_data                       - LANES x PSUM_W lane values
//   scale_in, bias_in              - captured when a tile completes
//   ppu_done                       - PPU releases the drained tile
//   partial_sum, scale, bias, valid - burst to PPU (registered)
//   sat_flag                       - sticky saturation since last drain start
//   tile_cnt                       - tiles released, wraps
//
// state     | meaning
// ACCUM     | no tile draining; waiting for a bank to complete
// DRAIN     | streaming the burst, cnt_q counts beats left
// WAIT_DONE | burst sent, holding the bank until ppu_done
module psum_drain
  import psum_drain_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic [3:0]              acc_row,
  input  logic                    acc_first,
  input  logic                    acc_last,
  input  logic [LANES*PSUM_W-1:0] acc_data,
  input  logic [7:0]              scale_in,
  input  logic [7:0]              bias_in,
  input  logic                    ppu_done,
  output logic [LANES*PSUM_W-1:0] partial_sum,
  output logic [7:0]              scale,
  output logic [7:0]              bias,
  output logic                    valid,
  output logic                    sat_flag,
  output logic [15:0]             tile_cnt
);

  localparam int DW = LANES*PSUM_W;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    buf_q [NBANK][ROWS];
  logic [ROWS-1:0]  mask_q [NBANK];
  logic [NBANK-1:0] full_q;
  logic [7:0]       scale_st_q [NBANK];
  logic [7:0]       bias_st_q [NBANK];
  logic             acc_bank_q;
  logic             drain_bank_q;

  logic [DW-1:0]    sum_b [NBANK];
  logic [LANES-1:0] sat_b [NBANK];

  logic             accept;
  logic             sat_now;
  logic [ROWS-1:0]  mask_next;
  logic             complete;
  logic             release_bank;
  logic             next_bank;
  logic             next_pending;
  logic [7:0]       start_scale;
  logic [7:0]       start_bias;
  logic [CNT_W-1:0] beat_d;
  logic [ROW_W-1:0] row_idx;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    psum_sat_add u_add (
      .row_in  (buf_q[b][acc_row]),
      .add_in  (acc_data),
      .first   (acc_first),
      .sum_out (sum_b[b]),
      .sat     (sat_b[b])
    );
  end

  // A bank stays unavailable from completion until ppu_done releases it.
  assign acc_ready    = ~full_q[acc_bank_q];
  assign accept       = acc_valid & acc_ready;
  assign sat_now      = accept & (|sat_b[acc_bank_q]);
  assign mask_next    = mask_q[acc_bank_q] | ({{(ROWS-1){1'b0}}, 1'b1} << acc_row);
  assign complete     = accept & acc_last & (&mask_next);
  assign release_bank = (state_q == WAIT_DONE) & ppu_done;

  // With two banks the other one may already be complete (or completing on
  // this very edge) when ppu_done arrives; it then drains back to back.
  assign next_bank    = (NBANK == 2) ? ~drain_bank_q : 1'b0;
  assign next_pending = (NBANK == 2) &
                        (full_q[next_bank] | (complete & (acc_bank_q == next_bank)));
  assign start_scale  = (complete & (acc_bank_q == next_bank)) ? scale_in : scale_st_q[next_bank];
  assign start_bias   = (complete & (acc_bank_q == next_bank)) ? bias_in  : bias_st_q[next_bank];

  // Beat 0 is a preamble repeating row 0, so beat d carries row d-1.
  assign beat_d  = CNT_W'(DRAIN_BEATS) - cnt_q;
  assign row_idx = (beat_d == '0) ? '0 : ROW_W'(beat_d - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      cnt_q        <= '0;
      partial_sum  <= '0;
      scale        <= '0;
      bias         <= '0;
      valid        <= 1'b0;
      sat_flag     <= 1'b0;
      tile_cnt     <= '0;
      drain_bank_q <= 1'b0;
    end else begin
      sat_flag <= sat_now |
                  (sat_flag & ~((state_q == DRAIN) && (cnt_q == CNT_W'(DRAIN_BEATS))));
      case (state_q)
        ACCUM: begin
          if (complete) begin
            state_q <= DRAIN;
            cnt_q   <= CNT_W'(DRAIN_BEATS);
            scale   <= scale_in;
            bias    <= bias_in;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q     <= WAIT_DONE;
            valid       <= 1'b0;
            partial_sum <= '0;
          end else begin
            valid       <= 1'b1;
            partial_sum <= buf_q[drain_bank_q][row_idx];
            cnt_q       <= cnt_q - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (ppu_done) begin
            tile_cnt     <= tile_cnt + 16'd1;
            drain_bank_q <= next_bank;
            if (next_pending) begin
              state_q <= DRAIN;
              cnt_q   <= CNT_W'(DRAIN_BEATS);
              scale   <= start_scale;
              bias    <= start_bias;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < ROWS; r++) buf_q[b][r] <= '0;
        mask_q[b]     <= '0;
        scale_st_q[b] <= '0;
        bias_st_q[b]  <= '0;
      end
      full_q     <= '0;
      acc_bank_q <= 1'b0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (release_bank && (drain_bank_q == 1'(b))) begin
          for (int r = 0; r < ROWS; r++) buf_q[b][r] <= '0;
          mask_q[b] <= '0;
          full_q[b] <= 1'b0;
        end else if (accept && (acc_bank_q == 1'(b))) begin
          buf_q[b][acc_row] <= sum_b[b];
          if (acc_last) mask_q[b] <= mask_next;
          if (complete) begin
            full_q[b]     <= 1'b1;
            scale_st_q[b] <= scale_in;
            bias_st_q[b]  <= bias_in;
          end
        end
      end
      if (complete) acc_bank_q <= (NBANK == 2) ? ~acc_bank_q : 1'b0;
    end
  end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Transmit side of the PPU partial-sum interface.
- Accumulates 16 rows × 16 lanes of 24-bit signed partial sums coming from the systolic array over K steps. On the final K step it streams the finished tile into the PPU as a fixed 17-beat burst, holding scale and bias stable.
- Waits for the PPU done pulse before releasing the tile buffer.
- Sits between the array accumulator outputs and the ppu block.

Parameters:
- ROWS, 16, rows per tile (beats per burst minus one).
- LANES, 16, lanes per row.
- PSUM_W, 24, bits per lane partial sum.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- acc_valid  in  1  accumulation beat present.
- acc_ready  out  1  beat accepted when acc_valid & acc_ready.
- acc_row  in  4  tile row addressed by the beat.
- acc_first  in  1  overwrite the row instead of adding (first K step).
- acc_last  in  1  final K step for this row.
- acc_data  in  384  16 × 24-bit signed lane values, lane j at [24j+:24].
- scale_in  in  8  FP8 E4M3 scale, captured at tile completion.
- bias_in  in  8  bias, captured at tile completion.
- ppu_done  in  1  PPU output-done pulse.
- partial_sum  out  384  burst data to PPU.
- scale  out  8  held scale to PPU.
- bias  out  8  held bias to PPU.
- valid  out  1  burst qualifier to PPU.
- sat_flag  out  1  sticky: any lane saturated since the last drain start.
- tile_cnt  out  16  tiles fully drained, wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state ACCUM, buffer zeroed, partial_sum=0, scale=0, bias=0, valid=0, acc_ready=1, sat_flag=0, tile_cnt=0, row_done mask=0.
- FSM states ACCUM, DRAIN, WAIT_DONE.
- ACCUM:
  - acc_ready=1.
  - On an accepted beat, row[acc_row] ← acc_first ? acc_data : sat(row + acc_data), lane-wise.
  - Saturation clamps to +8388607 / −8388608 and sets sat_flag.
  - When acc_last is accepted, the row_done bit for that row is set.
  - When row_done becomes all-ones, the FSM moves to DRAIN on the next edge. scale_in and bias_in are captured from the beat that completed the mask.
- Repeated acc_last on an already-done row: data still accumulates; the mask is unchanged.
- DRAIN:
  - acc_ready=0. Runs for 17 cycles with beat counter d=0..16.
  - valid=1 on all 17 beats.
  - Beat 0 is the preamble, partial_sum=row0. This matches the PPU sampling valid in IDLE and writing on the next 16 edges.
  - Beat d≥1: partial_sum=row[d−1].
  - Outputs are registered; scale and bias are held constant for the whole burst.
  - sat_flag clears on beat 0, unless saturation occurs in that same cycle (set wins).
  - After beat 16: valid=0, partial_sum=0, state WAIT_DONE.
- WAIT_DONE:
  - acc_ready=0.
  - On ppu_done=1: tile_cnt+1, row_done mask cleared, buffer zeroed, next state ACCUM.
  - scale and bias outputs remain held until the next capture.
- ppu_done outside WAIT_DONE is ignored.
- An acc_valid beat with acc_ready=0 is not accepted; the sender must hold it.
- Latency: last completing beat accepted at edge N → first valid at edge N+1 → last valid beat at edge N+17.
- Reset mid-burst: valid drops asynchronously to 0 and all state returns to reset values. No partial burst resumes.

Optional Feature:
- Macro PSUM_DRAIN_DOUBLE_BUF_EN.
- Defined:
  - Two tile banks. Accumulation switches to the idle bank as soon as DRAIN starts, so acc_ready stays 1 during DRAIN and WAIT_DONE.
  - acc_ready=0 only when both banks are complete and not yet released by ppu_done.
  - Banks alternate; tile_cnt counts released banks.
  - A completed second bank enters DRAIN on the cycle after ppu_done releases the first.
- Undefined: single bank; behaviour exactly as above.

Decomposition:
- Shared package holds:
  - the PSUM_W/LANES/ROWS constants;
  - the FSM state encoding;
  - the saturation limits SAT_MAX/SAT_MIN;
  - the DRAIN_BEATS=17 constant.
- One natural sub-module, psum_sat_add: LANES-wide combinational saturating add/overwrite, outputting the sum and a per-lane saturation flag. It is instantiated once per bank.

Test Plan:
- Single-step tile: 16 beats, acc_first=acc_last=1, row r lane j = r*16+j → 17 valid cycles; beat 0 = row0; beat d carries lane j = (d−1)*16+j. tile_cnt=1 after ppu_done.
- Accumulate 3 K steps of +1000 per lane (first, mid, last) → drained lanes all 3000; sat_flag=0.
- Saturation: row5 lane3 first=8000000 then +1000000 → drained value 8388607, sat_flag=1. Second first=−8000000 then −1000000 → −8388608.
- Backpressure: acc_valid held high during DRAIN/WAIT_DONE without the macro → acc_ready=0, no buffer change; the beat is accepted on the cycle after ppu_done.
- Reset asserted at drain beat 7 → valid=0 immediately, tile_cnt=0; a new full tile then drains correctly.
- With PSUM_DRAIN_DOUBLE_BUF_EN: second tile completes during WAIT_DONE → second burst starts the cycle after ppu_done; a third-tile beat stalls until the first bank is released.
